// File: rtl/desc_builder_pkg.sv
// Shared types, default configuration and saturating helpers for the keypoint descriptor builder.
package desc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_SUM,
        S_ARGMAX,
        S_EMIT,
        S_WRITE
    } state_t;

    localparam int DEF_NREG  = 4;
    localparam int DEF_NBIN  = 16;
    localparam int DEF_ACC_W = 16;
    localparam int REG_W     = $clog2(DEF_NREG);
    localparam int BIN_W     = $clog2(DEF_NBIN);
    localparam int COMB_W    = DEF_ACC_W + DEF_NREG;

    // a + b clamped to the largest w-bit value (w < 32)
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_shift(input logic [31:0] v, input int sh, input int w);
        logic [31:0] s;
        logic [31:0] lim;
        s   = v >> sh;
        lim = (32'd1 << w) - 32'd1;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/desc_builder_if.sv
// Sample, control, status and read-port bundle of the descriptor builder.
interface desc_builder_if
    import desc_pkg::*;
#(
    parameter int NREG    = DEF_NREG,
    parameter int NBIN    = DEF_NBIN,
    parameter int MAG_W   = 8,
    parameter int OUT_W   = 8,
    parameter int SEED_AW = 9
) ();
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int BW = $clog2(NBIN);
    localparam int DW = NREG * NBIN * OUT_W;

    logic               clear;
    logic               kp_start;
    logic               s_valid;
    logic               s_ready;
    logic [RW-1:0]      s_region;
    logic [BW-1:0]      s_ori;
    logic [MAG_W-1:0]   s_mag;
    logic               s_last;
    logic               busy;
    logic               desc_valid;
    logic [BW-1:0]      dom_ori;
    logic [SEED_AW:0]   desc_count;
    logic               full;
    logic               rd_en;
    logic [SEED_AW-1:0] rd_addr;
    logic [DW-1:0]      rd_data;

    modport master (
        output clear, kp_start, s_valid, s_region, s_ori, s_mag, s_last, rd_en, rd_addr,
        input  s_ready, busy, desc_valid, dom_ori, desc_count, full, rd_data
    );

    modport slave (
        input  clear, kp_start, s_valid, s_region, s_ori, s_mag, s_last, rd_en, rd_addr,
        output s_ready, busy, desc_valid, dom_ori, desc_count, full, rd_data
    );
endinterface

// File: rtl/desc_builder_store_ram.sv
// Descriptor store: one write port, one registered read port returning old data on collision.
module desc_store_ram #(
    parameter int AW = 9,
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/desc_builder.sv
// Keypoint descriptor builder: histogram accumulation, dominant-orientation search, rotate/scale, store.
// Optional DESC_NORM_EN: scale each descriptor so its largest element fills OUT_W bits.
module desc_builder
    import desc_pkg::*;
#(
    parameter int NREG      = DEF_NREG,
    parameter int NBIN      = DEF_NBIN,
    parameter int MAG_W     = 8,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 2,
    parameter int SEED_AW   = 9
) (
    input logic           clk,
    input logic           rst,
    desc_builder_if.slave bus
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int BW = $clog2(NBIN);
    localparam int CW = ACC_W + NREG;
    localparam int DW = NREG * NBIN * OUT_W;

    state_t             r_state, w_next;
    logic [ACC_W-1:0]   r_hist [NREG][NBIN];
    logic [CW-1:0]      r_comb [NBIN];
    logic [CW-1:0]      w_comb [NBIN];
    logic [BW-1:0]      r_scan, r_dom, r_dom_ori;
    logic [CW-1:0]      r_best;
    logic [DW-1:0]      r_desc, w_desc;
    logic [SEED_AW-1:0] r_wptr;
    logic [SEED_AW:0]   r_count;
    logic               r_desc_valid;
    logic               w_full, w_accept, w_clr_hist, w_we;
    int                 w_shift;

    assign w_full = (r_count == {1'b1, {SEED_AW{1'b0}}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // kp_start both opens a keypoint from IDLE and aborts one in ACCUM; either way the histograms restart
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_clr_hist = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.kp_start && !w_full) begin
                    w_clr_hist = 1'b1;
                    w_next     = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.kp_start) begin
                    w_clr_hist = 1'b1;
                end else if (bus.s_valid) begin
                    w_accept = 1'b1;
                    if (bus.s_last) w_next = S_SUM;
                end
            end
            S_SUM:    w_next = S_ARGMAX;
            S_ARGMAX: if (r_scan == BW'(NBIN - 1)) w_next = S_EMIT;
            S_EMIT:   w_next = S_WRITE;
            S_WRITE: begin
                w_we   = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++)
                for (int b = 0; b < NBIN; b++)
                    r_hist[r][b] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                for (int b = 0; b < NBIN; b++)
                    if (w_clr_hist)
                        r_hist[r][b] <= '0;
                    else if (w_accept && bus.s_region == RW'(r) && bus.s_ori == BW'(b))
                        r_hist[r][b] <= ACC_W'(sat_add(32'(r_hist[r][b]), 32'(bus.s_mag), ACC_W));
        end
    end

    // Region r is weighted by 2^r; CW leaves room for the worst-case sum
    always_comb begin
        for (int b = 0; b < NBIN; b++) begin
            w_comb[b] = '0;
            for (int r = 0; r < NREG; r++)
                w_comb[b] = w_comb[b] + (CW'(r_hist[r][b]) << r);
        end
    end

`ifdef DESC_NORM_EN
    logic [ACC_W-1:0] r_max, w_bin_max;

    always_comb begin
        w_bin_max = '0;
        for (int r = 0; r < NREG; r++)
            if (r_hist[r][r_scan] > w_bin_max) w_bin_max = r_hist[r][r_scan];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_max <= '0;
        else if (r_state == S_SUM)    r_max <= '0;
        else if (r_state == S_ARGMAX && w_bin_max > r_max) r_max <= w_bin_max;
    end

    always_comb begin
        w_shift = 0;
        for (int i = 0; i < ACC_W; i++)
            if (r_max[i]) w_shift = (i + 1 > OUT_W) ? i + 1 - OUT_W : 0;
    end
`else
    assign w_shift = OUT_SHIFT;
`endif

    // Element k of every region is taken from bin (k + dom) so the dominant orientation lands at k = 0
    always_comb begin
        w_desc = '0;
        for (int r = 0; r < NREG; r++)
            for (int k = 0; k < NBIN; k++)
                w_desc[(r*NBIN+k)*OUT_W +: OUT_W] =
                    OUT_W'(sat_shift(32'(r_hist[r][BW'(k) + r_dom]), w_shift, OUT_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NBIN; b++) r_comb[b] <= '0;
            r_scan       <= '0;
            r_best       <= '0;
            r_dom        <= '0;
            r_dom_ori    <= '0;
            r_desc       <= '0;
            r_wptr       <= '0;
            r_count      <= '0;
            r_desc_valid <= 1'b0;
        end else begin
            r_desc_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clear) begin
                        r_wptr  <= '0;
                        r_count <= '0;
                    end
                end
                S_SUM: begin
                    for (int b = 0; b < NBIN; b++) r_comb[b] <= w_comb[b];
                    r_scan <= '0;
                    r_best <= '0;
                    r_dom  <= '0;
                end
                S_ARGMAX: begin
                    if (r_comb[r_scan] > r_best) begin
                        r_best <= r_comb[r_scan];
                        r_dom  <= r_scan;
                    end
                    r_scan <= r_scan + 1'b1;
                end
                S_EMIT: r_desc <= w_desc;
                S_WRITE: begin
                    r_wptr       <= r_wptr + 1'b1;
                    r_count      <= r_count + 1'b1;
                    r_desc_valid <= 1'b1;
                    r_dom_ori    <= r_dom;
                end
                default: ;
            endcase
        end
    end

    desc_store_ram #(
        .AW(SEED_AW),
        .DW(DW)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (r_desc),
        .i_re    (bus.rd_en),
        .i_raddr (bus.rd_addr),
        .o_rdata (bus.rd_data)
    );

    assign bus.s_ready    = (r_state == S_ACCUM);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.desc_valid = r_desc_valid;
    assign bus.dom_ori    = r_dom_ori;
    assign bus.desc_count = r_count;
    assign bus.full       = w_full;
endmodule

// File: tb/tb_desc_builder.sv
// Directed bench for desc_builder with a 4-entry store; expectations follow DESC_NORM_EN when defined.
module tb_desc_builder;
    import desc_pkg::*;

    localparam int NREG    = DEF_NREG;
    localparam int NBIN    = DEF_NBIN;
    localparam int ACC_W   = COMB_W - NREG;
    localparam int RW      = REG_W;
    localparam int BW      = BIN_W;
    localparam int SEED_AW = 2;
    localparam int DW      = NREG * NBIN * 8;

`ifdef DESC_NORM_EN
    localparam logic [7:0] E1 = 8'd200, E2A = 8'd20, E2B = 8'd100, E3 = 8'd8;
`else
    localparam logic [7:0] E1 = 8'd50,  E2A = 8'd5,  E2B = 8'd25,  E3 = 8'd2;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   lat;
    logic [DW-1:0] expDesc [4];

    desc_builder_if #(.NREG(NREG), .NBIN(NBIN), .MAG_W(8), .OUT_W(8), .SEED_AW(SEED_AW)) bus ();

    desc_builder #(
        .NREG(NREG), .NBIN(NBIN), .MAG_W(8), .ACC_W(ACC_W),
        .OUT_W(8), .OUT_SHIFT(2), .SEED_AW(SEED_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] elem(input int r, input int k, input logic [7:0] v);
        logic [DW-1:0] d;
        d = '0;
        d[(r*NBIN+k)*8 +: 8] = v;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int region, input int ori, input int mag, input logic last);
        bus.s_valid  = 1'b1;
        bus.s_region = RW'(region);
        bus.s_ori    = BW'(ori);
        bus.s_mag    = 8'(mag);
        bus.s_last   = last;
        @(posedge clk); #1;
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
    endtask

    task automatic kpStart();
        bus.kp_start = 1'b1;
        @(posedge clk); #1;
        bus.kp_start = 1'b0;
    endtask

    task automatic waitCommit(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.desc_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic readAddr(input int a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = SEED_AW'(a);
        @(posedge clk); #1;
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        expDesc[0] = elem(0, 0, E1);
        expDesc[1] = elem(3, 0, E2A) | elem(0, 12, E2B);
        expDesc[2] = elem(1, 0, E3) | elem(1, 5, E3);
        expDesc[3] = elem(2, 0, 8'd255);

        rst = 1'b0;
        bus.clear = 0; bus.kp_start = 0; bus.s_valid = 0; bus.s_region = '0;
        bus.s_ori = '0; bus.s_mag = '0; bus.s_last = 0; bus.rd_en = 0; bus.rd_addr = '0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.clear    = 1'($urandom);
            bus.kp_start = 1'($urandom);
            bus.s_valid  = 1'($urandom);
            bus.s_region = RW'($urandom);
            bus.s_ori    = BW'($urandom);
            bus.s_mag    = 8'($urandom);
            bus.s_last   = 1'($urandom);
            bus.rd_en    = 1'($urandom);
            bus.rd_addr  = SEED_AW'($urandom);
        end
        checkOutput("rst_s_ready",    DW'(bus.s_ready),    '0);
        checkOutput("rst_busy",       DW'(bus.busy),       '0);
        checkOutput("rst_desc_valid", DW'(bus.desc_valid), '0);
        checkOutput("rst_dom_ori",    DW'(bus.dom_ori),    '0);
        checkOutput("rst_desc_count", DW'(bus.desc_count), '0);
        checkOutput("rst_full",       DW'(bus.full),       '0);
        checkOutput("rst_rd_data",    bus.rd_data,         '0);

        @(negedge clk);
        bus.clear = 0; bus.kp_start = 0; bus.s_valid = 0; bus.s_last = 0; bus.rd_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("idle_s_ready", DW'(bus.s_ready), '0);
        checkOutput("idle_busy",    DW'(bus.busy),    '0);

        $display("[TB] single sample");
        bus.s_valid = 1'b1; bus.s_region = RW'(0); bus.s_ori = BW'(1); bus.s_mag = 8'd60;
        kpStart();
        bus.s_valid = 1'b0;
        checkOutput("t1_busy",    DW'(bus.busy),    DW'(1));
        checkOutput("t1_s_ready", DW'(bus.s_ready), DW'(1));
        applyStimulus(0, 3, 200, 1'b1);
        waitCommit(lat);
        checkOutput("t1_latency", DW'(lat),            DW'(19));
        checkOutput("t1_dom_ori", DW'(bus.dom_ori),    DW'(3));
        checkOutput("t1_count",   DW'(bus.desc_count), DW'(1));
        @(posedge clk); #1;
        checkOutput("t1_pulse",   DW'(bus.desc_valid), '0);
        readAddr(0);
        checkOutput("t1_desc",    bus.rd_data, expDesc[0]);

        $display("[TB] weighting and rotation");
        kpStart();
        applyStimulus(0, 5, 100, 1'b0);
        applyStimulus(3, 9, 20, 1'b1);
        waitCommit(lat);
        checkOutput("t2_latency", DW'(lat),            DW'(19));
        checkOutput("t2_dom_ori", DW'(bus.dom_ori),    DW'(9));
        checkOutput("t2_count",   DW'(bus.desc_count), DW'(2));
        readAddr(1);
        checkOutput("t2_desc",    bus.rd_data, expDesc[1]);

        $display("[TB] tie and abort");
        kpStart();
        applyStimulus(1, 2, 8, 1'b0);
        bus.s_valid = 1'b1; bus.s_region = RW'(1); bus.s_ori = BW'(7); bus.s_mag = 8'd100;
        kpStart();
        bus.s_valid = 1'b0;
        applyStimulus(1, 7, 8, 1'b0);
        applyStimulus(1, 2, 8, 1'b1);
        waitCommit(lat);
        checkOutput("t3_latency", DW'(lat),            DW'(19));
        checkOutput("t3_dom_ori", DW'(bus.dom_ori),    DW'(2));
        checkOutput("t3_count",   DW'(bus.desc_count), DW'(3));
        readAddr(2);
        checkOutput("t3_desc",    bus.rd_data, expDesc[2]);

        $display("[TB] saturation");
        kpStart();
        for (int i = 0; i < 300; i++) applyStimulus(2, 0, 255, i == 299);
        waitCommit(lat);
        checkOutput("t4_latency", DW'(lat),            DW'(19));
        checkOutput("t4_dom_ori", DW'(bus.dom_ori),    DW'(0));
        checkOutput("t4_count",   DW'(bus.desc_count), DW'(4));
        checkOutput("t4_full",    DW'(bus.full),       DW'(1));
        @(posedge clk); #1;

        $display("[TB] full and clear");
        kpStart();
        checkOutput("full_busy",    DW'(bus.busy),    '0);
        checkOutput("full_s_ready", DW'(bus.s_ready), '0);
        @(posedge clk); #1;
        checkOutput("full_busy2",   DW'(bus.busy),    '0);
        for (int a = 0; a < 4; a++) begin
            readAddr(a);
            checkOutput($sformatf("read_%0d", a), bus.rd_data, expDesc[a]);
        end
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        checkOutput("clr_count", DW'(bus.desc_count), '0);
        checkOutput("clr_full",  DW'(bus.full),       '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
